// File: rtl/move_scheduler_pkg.sv
// move_scheduler_pkg
//   Shared definitions for the platform move scheduler and the y counter
//   that consumes its move codes.
//   - move_t / MV_* : 2-bit move code carried on move[1:0]
//   - state_e       : scheduler FSM state encoding
//   - KEY_*         : bit positions of the push buttons in keys[2:0]
//   - pick_move()   : fixed-priority resolution of simultaneous presses
package move_scheduler_pkg;

  typedef logic [1:0] move_t;

  localparam move_t MV_NONE  = 2'b00;
  localparam move_t MV_CLIMB = 2'b01;
  localparam move_t MV_HOP   = 2'b10;
  localparam move_t MV_DROP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MOVING  = 2'b01,
    ST_RELEASE = 2'b10
  } state_e;

  localparam int unsigned NUM_KEYS  = 3;
  localparam int unsigned KEY_CLIMB = 0;
  localparam int unsigned KEY_HOP   = 1;
  localparam int unsigned KEY_DROP  = 2;

  // Climb beats hop beats drop; the losing presses are simply dropped.
  function automatic move_t pick_move(input logic [NUM_KEYS-1:0] press);
    if (press[KEY_CLIMB]) return MV_CLIMB;
    if (press[KEY_HOP])   return MV_HOP;
    if (press[KEY_DROP])  return MV_DROP;
    return MV_NONE;
  endfunction

endpackage

// File: rtl/move_scheduler_tick_divider.sv
// tick_divider
//   Free-running divider producing a one-cycle strobe every TICK_DIV clocks.
//   The count runs 0..TICK_DIV-1 and wraps; tick is high while the count
//   sits at TICK_DIV-1, so the first strobe is in the TICK_DIV-th cycle
//   after reset release. TICK_DIV is expected to be at least 2.
//   Ports:
//     clk    : clock
//     resetn : asynchronous active-low reset, clears the count
//     tick   : single-cycle strobe
module tick_divider #(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler
//   Turns raw push-button presses into move requests for the y counter,
//   tracks the platform level and aborts moves that run too long.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for a press; refuses impossible climbs/drops
//   ST_MOVING  | move code held on 'move', waiting for move_over or timeout
//   ST_RELEASE | move finished; waiting for every key to be released
//
//   Ports:
//     clk       : sole clock
//     resetn    : asynchronous active-low reset
//     keys[2:0] : raw active-low buttons, [0] climb, [1] hop, [2] drop
//     move_over : completion flag from the y counter
//     move[1:0] : move code to the y counter (MV_* in the package)
//     update    : one-cycle strobe every TICK_DIV clocks
//     level[1:0]: current platform level, 0 = bottom
//     busy      : high while a move is in progress
//     reject    : one-cycle pulse when a press is refused
//     fault     : one-cycle pulse when a move is aborted by timeout
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 833333,
  parameter int unsigned NUM_LEVELS    = 3,
  parameter int unsigned TIMEOUT_TICKS = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] keys,
  input  logic       move_over,
  output logic [1:0] move,
  output logic       update,
  output logic [1:0] level,
  output logic       busy,
  output logic       reject,
  output logic       fault
);

  localparam int unsigned AGE_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT_TICKS);
  localparam logic [1:0] LEVEL_TOP = 2'(NUM_LEVELS - 1);

  // --------------------------------------------------------------------
  // Update strobe
  // --------------------------------------------------------------------
  logic tick;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .resetn(resetn),
    .tick  (tick)
  );

  assign update = tick;

  // --------------------------------------------------------------------
  // Key synchronisers and press detection
  // --------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_s1;
  logic [NUM_KEYS-1:0] key_s2;
  logic [NUM_KEYS-1:0] key_s3;
  logic [NUM_KEYS-1:0] key_armed;
  logic [NUM_KEYS-1:0] press_req;
  logic [1:0]          warm;

  // The synchronisers come out of reset reading "released", so a key held
  // through reset would look like a fresh press once its low level reaches
  // key_s2. A key is therefore only armed after its synchronised level has
  // been seen high with real pin data in the pipe (warm == 2).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_s1    <= '1;
      key_s2    <= '1;
      key_s3    <= '1;
      key_armed <= '0;
      press_req <= '0;
      warm      <= '0;
    end else begin
      key_s1 <= keys;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      if (warm != 2'd2) begin
        warm <= warm + 2'd1;
      end else begin
        key_armed <= key_armed | key_s2;
      end
      press_req <= key_armed & key_s3 & ~key_s2;
    end
  end

  // --------------------------------------------------------------------
  // Move FSM
  // --------------------------------------------------------------------
  state_e           state;
  state_e           state_n;
  move_t            move_n;
  move_t            req_code;
  logic [1:0]       level_n;
  logic [AGE_W-1:0] age;
  logic [AGE_W-1:0] age_n;
  logic             reject_n;
  logic             fault_n;
  logic             refuse;

  assign req_code = pick_move(press_req);
  assign refuse   = ((req_code == MV_CLIMB) && (level == LEVEL_TOP)) ||
                    ((req_code == MV_DROP)  && (level == 2'd0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      move   <= MV_NONE;
      level  <= 2'd0;
      age    <= '0;
      reject <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_n;
      move   <= move_n;
      level  <= level_n;
      age    <= age_n;
      reject <= reject_n;
      fault  <= fault_n;
    end
  end

  always_comb begin
    state_n  = state;
    move_n   = move;
    level_n  = level;
    age_n    = age;
    reject_n = 1'b0;
    fault_n  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        age_n = '0;
        if (req_code != MV_NONE) begin
          if (refuse) begin
            reject_n = 1'b1;
          end else begin
            move_n  = req_code;
            state_n = ST_MOVING;
          end
        end
      end

      ST_MOVING: begin
        if (tick && (age != AGE_LIMIT)) begin
          age_n = age + AGE_W'(1);
        end
        // move_over is checked first so it wins over a coincident timeout.
        if (move_over) begin
          move_n  = MV_NONE;
          state_n = ST_RELEASE;
          if (move == MV_CLIMB) begin
            level_n = level + 2'd1;
          end else if (move == MV_DROP) begin
            level_n = level - 2'd1;
          end
        end else if (age_n == AGE_LIMIT) begin
          move_n  = MV_NONE;
          fault_n = 1'b1;
          state_n = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (key_s2 == '1) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        move_n  = MV_NONE;
      end
    endcase
  end

  assign busy = (state == ST_MOVING);

endmodule
